// File: rtl/supercar_hex_monitor.sv
// Receive-side checker for the Supercar sweep display: decodes HEX0..HEX3 back into
// lamp position and direction, measures per-step dwell, counts sweeps, flags protocol errors.
module supercar_hex_monitor #(
    parameter logic [6:0]  LIT_PATTERN   = 7'b0111111,
    parameter logic [6:0]  BLANK_PATTERN = 7'b1111111,
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned SWP_W         = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [6:0]       HEX0,
    input  logic [6:0]       HEX1,
    input  logic [6:0]       HEX2,
    input  logic [6:0]       HEX3,
    input  logic             ERR_CLR,
    output logic [1:0]       POS,
    output logic             POS_VALID,
    output logic             DIR,
    output logic             STEP,
    output logic [CNT_W-1:0] LAST_DWELL,
    output logic [SWP_W-1:0] SWEEP_COUNT,
    output logic             ERR_PATTERN,
    output logic             ERR_JUMP,
    output logic             ERR_REVERSE
);

    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

    logic [3:0][6:0]   hex_q, hex_d;
    logic              frame_vld_q, frame_vld_d;
    logic [1:0]        pos_q, pos_d;
    logic              pos_valid_q, pos_valid_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic [CNT_W-1:0]  last_dwell_q, last_dwell_d;
    logic [CNT_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [SWP_W-1:0]  sweep_q, sweep_d;
    logic              err_pattern_q, err_pattern_d;
    logic              err_jump_q, err_jump_d;
    logic              err_reverse_q, err_reverse_d;
    logic              hist_q, hist_d;
    logic              dir_ok_q, dir_ok_d;
    logic              dwell_ok_q, dwell_ok_d;

    logic [2:0]        lit_cnt;
    logic [2:0]        blank_cnt;
    logic [1:0]        new_pos;
    logic              legal;
    logic              adjacent;
    logic              step_dir;
    logic              at_end;

    // Frame decode of the registered digits
    always_comb begin
        lit_cnt   = 3'd0;
        blank_cnt = 3'd0;
        new_pos   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (hex_q[i] == LIT_PATTERN) begin
                lit_cnt = lit_cnt + 3'd1;
                new_pos = 2'(i);
            end
            if (hex_q[i] == BLANK_PATTERN) begin
                blank_cnt = blank_cnt + 3'd1;
            end
        end
    end

    assign legal    = (lit_cnt == 3'd1) && (blank_cnt == 3'd3);
    assign adjacent = ({1'b0, new_pos} == {1'b0, pos_q} + 3'd1) ||
                      ({1'b0, pos_q} == {1'b0, new_pos} + 3'd1);
    assign step_dir = (new_pos < pos_q);
    assign at_end   = (pos_q == 2'd0) || (pos_q == 2'd3);

    // dwell_ok tracks whether the last position change was a STEP, so LAST_DWELL
    // only ever holds a true STEP-to-STEP distance
    always_comb begin
        hex_d         = {HEX3, HEX2, HEX1, HEX0};
        frame_vld_d   = 1'b1;
        pos_d         = pos_q;
        pos_valid_d   = pos_valid_q;
        dir_d         = dir_q;
        step_d        = 1'b0;
        last_dwell_d  = last_dwell_q;
        dwell_cnt_d   = dwell_cnt_q;
        sweep_d       = sweep_q;
        err_pattern_d = err_pattern_q & ~ERR_CLR;
        err_jump_d    = err_jump_q & ~ERR_CLR;
        err_reverse_d = err_reverse_q & ~ERR_CLR;
        hist_d        = hist_q;
        dir_ok_d      = dir_ok_q;
        dwell_ok_d    = dwell_ok_q;

        if (frame_vld_q) begin
            if (!legal) begin
                pos_valid_d   = 1'b0;
                err_pattern_d = 1'b1;
                hist_d        = 1'b0;
                dir_ok_d      = 1'b0;
                dwell_ok_d    = 1'b0;
            end else if (!hist_q) begin
                pos_d       = new_pos;
                pos_valid_d = 1'b1;
                hist_d      = 1'b1;
                dwell_cnt_d = CNT_W'(1);
            end else if (new_pos == pos_q) begin
                pos_valid_d = 1'b1;
                if (dwell_cnt_q != DWELL_MAX) begin
                    dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
                end
            end else if (adjacent) begin
                pos_d       = new_pos;
                pos_valid_d = 1'b1;
                step_d      = 1'b1;
                dwell_cnt_d = CNT_W'(1);
                dwell_ok_d  = 1'b1;
                if (dwell_ok_q) begin
                    last_dwell_d = dwell_cnt_q;
                end
                if (!dir_ok_q) begin
                    dir_d    = step_dir;
                    dir_ok_d = 1'b1;
                end else if (step_dir != dir_q) begin
                    dir_d = step_dir;
                    if (at_end) begin
                        sweep_d = sweep_q + SWP_W'(1);
                    end else begin
                        err_reverse_d = 1'b1;
                    end
                end
            end else begin
                pos_d       = new_pos;
                pos_valid_d = 1'b1;
                err_jump_d  = 1'b1;
                dwell_cnt_d = CNT_W'(1);
                dwell_ok_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hex_q         <= '0;
            frame_vld_q   <= 1'b0;
            pos_q         <= 2'd0;
            pos_valid_q   <= 1'b0;
            dir_q         <= 1'b0;
            step_q        <= 1'b0;
            last_dwell_q  <= '0;
            dwell_cnt_q   <= '0;
            sweep_q       <= '0;
            err_pattern_q <= 1'b0;
            err_jump_q    <= 1'b0;
            err_reverse_q <= 1'b0;
            hist_q        <= 1'b0;
            dir_ok_q      <= 1'b0;
            dwell_ok_q    <= 1'b0;
        end else begin
            hex_q         <= hex_d;
            frame_vld_q   <= frame_vld_d;
            pos_q         <= pos_d;
            pos_valid_q   <= pos_valid_d;
            dir_q         <= dir_d;
            step_q        <= step_d;
            last_dwell_q  <= last_dwell_d;
            dwell_cnt_q   <= dwell_cnt_d;
            sweep_q       <= sweep_d;
            err_pattern_q <= err_pattern_d;
            err_jump_q    <= err_jump_d;
            err_reverse_q <= err_reverse_d;
            hist_q        <= hist_d;
            dir_ok_q      <= dir_ok_d;
            dwell_ok_q    <= dwell_ok_d;
        end
    end

    assign POS         = pos_q;
    assign POS_VALID   = pos_valid_q;
    assign DIR         = dir_q;
    assign STEP        = step_q;
    assign LAST_DWELL  = last_dwell_q;
    assign SWEEP_COUNT = sweep_q;
    assign ERR_PATTERN = err_pattern_q;
    assign ERR_JUMP    = err_jump_q;
    assign ERR_REVERSE = err_reverse_q;

endmodule

// File: tb/tb_supercar_hex_monitor.sv
// Self-checking bench for supercar_hex_monitor: hand-computed frame segments through a
// scoreboard queue, plus explicit sequences for latency, error priority and async reset.
module tb_supercar_hex_monitor;

    localparam logic [6:0] LIT = 7'b0111111;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] BAD = 7'b0000110;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        err_clr;
    logic [1:0]  pos;
    logic        pos_valid, dir, step;
    logic [27:0] last_dwell;
    logic [15:0] sweep_count;
    logic        err_pattern, err_jump, err_reverse;

    supercar_hex_monitor dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .HEX0        (hex0),
        .HEX1        (hex1),
        .HEX2        (hex2),
        .HEX3        (hex3),
        .ERR_CLR     (err_clr),
        .POS         (pos),
        .POS_VALID   (pos_valid),
        .DIR         (dir),
        .STEP        (step),
        .LAST_DWELL  (last_dwell),
        .SWEEP_COUNT (sweep_count),
        .ERR_PATTERN (err_pattern),
        .ERR_JUMP    (err_jump),
        .ERR_REVERSE (err_reverse)
    );

    always #5 clk = ~clk;

    // f: 0..3 lit position, 4 all blank, 5 two lit, 6 illegal code
    typedef struct {
        int f; int cyc; bit clr;
        int pos; bit pv; bit dir; int ld; int sw; bit ep; bit ej; bit er; int st;
    } vec_t;

    vec_t tbl[20];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_cnt = 0;

    always @(negedge clk) if (step) step_cnt++;

    function automatic vec_t mk(input int f, input int cyc, input bit clr, input int p,
                                input bit pv, input bit d, input int ld, input int sw,
                                input bit ep, input bit ej, input bit er, input int st);
        vec_t v;
        v.f = f; v.cyc = cyc; v.clr = clr; v.pos = p; v.pv = pv; v.dir = d;
        v.ld = ld; v.sw = sw; v.ep = ep; v.ej = ej; v.er = er; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_frame(input int f);
        hex0 = BLK; hex1 = BLK; hex2 = BLK; hex3 = BLK;
        case (f)
            0: hex0 = LIT;
            1: hex1 = LIT;
            2: hex2 = LIT;
            3: hex3 = LIT;
            5: begin hex0 = LIT; hex2 = LIT; end
            6: hex1 = BAD;
            default: ;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input vec_t e, input int steps);
        chk($sformatf("%s.pos", tag), int'(pos), e.pos);
        chk($sformatf("%s.pos_valid", tag), int'(pos_valid), int'(e.pv));
        chk($sformatf("%s.dir", tag), int'(dir), int'(e.dir));
        chk($sformatf("%s.last_dwell", tag), int'(last_dwell), e.ld);
        chk($sformatf("%s.sweep", tag), int'(sweep_count), e.sw);
        chk($sformatf("%s.err_pattern", tag), int'(err_pattern), int'(e.ep));
        chk($sformatf("%s.err_jump", tag), int'(err_jump), int'(e.ej));
        chk($sformatf("%s.err_reverse", tag), int'(err_reverse), int'(e.er));
        chk($sformatf("%s.steps", tag), steps, e.st);
    endtask

    // Hold one frame for e.cyc cycles, then compare against the queued expectation
    task automatic run_seg(input string tag, input vec_t e);
        vec_t got;
        int   base;
        set_frame(e.f);
        err_clr = e.clr;
        base = step_cnt;
        exp_q.push_back(e);
        tick(e.cyc);
        got = exp_q.pop_front();
        check_outputs(tag, got, step_cnt - base);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        //            f cyc clr pos pv dir ld sw ep ej er st
        tbl[0]  = mk(0, 8, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8, 0,  1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(2, 8, 0,  2, 1, 0, 8, 0, 0, 0, 0, 1);
        tbl[3]  = mk(3, 8, 0,  3, 1, 0, 8, 0, 0, 0, 0, 1);
        tbl[4]  = mk(2, 8, 0,  2, 1, 1, 8, 1, 0, 0, 0, 1);
        tbl[5]  = mk(1, 8, 0,  1, 1, 1, 8, 1, 0, 0, 0, 1);
        tbl[6]  = mk(0, 8, 0,  0, 1, 1, 8, 1, 0, 0, 0, 1);
        tbl[7]  = mk(1, 5, 0,  1, 1, 0, 8, 2, 0, 0, 0, 1);
        tbl[8]  = mk(0, 8, 0,  0, 1, 1, 5, 2, 0, 0, 1, 1);
        tbl[9]  = mk(0, 6, 1,  0, 1, 1, 5, 2, 0, 0, 0, 0);
        tbl[10] = mk(2, 8, 0,  2, 1, 1, 5, 2, 0, 1, 0, 0);
        tbl[11] = mk(1, 7, 0,  1, 1, 1, 5, 2, 0, 1, 0, 1);
        tbl[12] = mk(0, 3, 0,  0, 1, 1, 7, 2, 0, 1, 0, 1);
        tbl[13] = mk(4, 2, 0,  0, 0, 1, 7, 2, 1, 1, 0, 0);
        tbl[14] = mk(2, 4, 0,  2, 1, 1, 7, 2, 1, 1, 0, 0);
        tbl[15] = mk(3, 4, 0,  3, 1, 0, 7, 2, 1, 1, 0, 1);
        tbl[16] = mk(3, 3, 1,  3, 1, 0, 7, 2, 0, 0, 0, 0);
        tbl[17] = mk(5, 2, 0,  3, 0, 0, 7, 2, 1, 0, 0, 0);
        tbl[18] = mk(6, 2, 0,  3, 0, 0, 7, 2, 1, 0, 0, 0);
        tbl[19] = mk(3, 3, 1,  3, 1, 0, 7, 2, 0, 0, 0, 0);

        rst = 1'b1;
        err_clr = 1'b0;
        set_frame(4);
        tick(3);
        check_outputs("reset", mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        chk("reset.step", int'(step), 0);

        // Two-edge latency of the first legal frame
        rst = 1'b0;
        set_frame(0);
        tick(1);
        chk("latency.edge1.pos_valid", int'(pos_valid), 0);
        tick(1);
        chk("latency.edge2.pos_valid", int'(pos_valid), 1);
        chk("latency.edge2.pos", int'(pos), 0);

        for (int i = 0; i < 20; i++) begin
            run_seg($sformatf("row%0d", i), tbl[i]);
        end

        // Illegal frame together with ERR_CLR: the error must win
        run_seg("errwin.bad", mk(6, 2, 1, 3, 0, 0, 7, 2, 1, 0, 0, 0));
        run_seg("errwin.clear", mk(3, 3, 1, 3, 1, 0, 7, 2, 0, 0, 0, 0));
        err_clr = 1'b0;

        // First step after history clear: direction taken from the step, no sweep count
        run_seg("prerst", mk(2, 3, 0, 2, 1, 1, 7, 2, 0, 0, 0, 1));

        // Asynchronous reset between clock edges
        #1;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        chk("async_rst.step", int'(step), 0);
        tick(1);
        rst = 1'b0;
        run_seg("post_rst.first", mk(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        run_seg("post_rst.step1", mk(2, 3, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1));
        run_seg("post_rst.step2", mk(3, 3, 0, 3, 1, 0, 3, 0, 0, 0, 0, 1));
        run_seg("post_rst.bounce", mk(2, 3, 0, 2, 1, 1, 3, 1, 0, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
